// File: rtl/bd_sync_rx_if.sv
// Bundled-data request/ack channel plus the clocked valid/ready output stream
// of the bd_sync_rx receiver, bundled as one port.
interface bd_sync_rx_if #(
    parameter int N = 1
);
    logic         req;
    logic [N-1:0] data;
    logic         ack;
    logic [N-1:0] o_data;
    logic         o_valid;
    logic         o_ready;

    modport master (
        output req,
        output data,
        output o_ready,
        input  ack,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  req,
        input  data,
        input  o_ready,
        output ack,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/bd_sync_rx.sv
// Async-to-sync boundary for delay-matched pipelines: synchronises a 4-phase
// bundled-data request, captures each token into a FIFO, emits valid/ready.
module bd_sync_rx #(
    parameter  int N     = 1,
    parameter  int DEPTH = 4,
    parameter  int SYNC  = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    bd_sync_rx_if.slave   bus,
    output logic [CW-1:0] count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           ack_q, ack_d;
    logic [SYNC-1:0] sync_q;
    logic           req_s;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count_q;
    logic           full;
    logic           push;
    logic           pop;
    logic [N-1:0]   mem [DEPTH];

    // Only the last synchroniser stage may reach the FSM.
    assign req_s = sync_q[SYNC-1];
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = bus.o_valid && bus.o_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], bus.req};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                // Full stalls the channel: ack stays low until space appears.
                if (req_s && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the storage array has no reset; occupancy is governed by the
    // pointers and count, so stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.o_valid = (count_q != '0);
    assign bus.o_data  = mem[rd_ptr];
    assign count       = count_q;

    // Registered full check makes overflow unreachable; pop is gated by o_valid.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        count_q <= CW'(DEPTH));
    a_push_only_when_space : assert property (@(posedge clk) disable iff (!rst)
        push |-> !full);

endmodule

// File: tb/tb_bd_sync_rx.sv
// Self-checking bench for bd_sync_rx (N=8, DEPTH=4, SYNC=2): vector table,
// directed corner sequences and a randomized stream against a queue model.
module tb_bd_sync_rx;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [CW-1:0] count;

    bd_sync_rx_if #(.N(N)) bus ();

    bd_sync_rx #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (bus.ack !== lvl && n < 12) begin
            tick();
            n++;
        end
        check(name, 32'(bus.ack), 32'(lvl));
    endtask

    task automatic send_token(input logic [N-1:0] d);
        bus.data = d;
        bus.req  = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        bus.req = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic drain(input logic [N-1:0] first, input int n);
        bus.o_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(bus.o_valid), 32'd1);
            check("drain_data", 32'(bus.o_data), 32'(first + N'(i)));
            tick();
        end
        bus.o_ready = 1'b0;
        check("drain_empty_valid", 32'(bus.o_valid), 32'd0);
        check("drain_empty_count", 32'(count), 32'd0);
    endtask

    typedef struct {
        logic          rst;
        logic          req;
        logic [N-1:0]  data;
        logic          rdy;
        logic          ack;
        logic          valid;
        logic [CW-1:0] cnt;
        logic          chk_data;
        logic [N-1:0]  odata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    logic [N-1:0] q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.req     = 1'b0;
        bus.data    = '0;
        bus.o_ready = 1'b0;

        // Reset held with req toggling, then release; then one token of 0xA5.
        vecs[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'hA5};
        vecs[9]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'hA5};
        vecs[10] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'hA5};
        vecs[11] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'hA5};
        vecs[12] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 8'hA5};
        vecs[13] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};

        for (int i = 0; i < NV; i++) begin
            rst         = vecs[i].rst;
            bus.req     = vecs[i].req;
            bus.data    = vecs[i].data;
            bus.o_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
            check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_data", i), 32'(bus.o_data), 32'(vecs[i].odata));
            end
        end

        // Fill to DEPTH, stall a fifth token, free one slot and watch it land.
        for (int i = 1; i <= DEPTH; i++) begin
            send_token(N'(i));
        end
        check("fill_count", 32'(count), 32'(DEPTH));
        bus.data = 8'h05;
        bus.req  = 1'b1;
        repeat (8) tick();
        check("stall_ack", 32'(bus.ack), 32'd0);
        check("stall_count", 32'(count), 32'(DEPTH));
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
        check("pop_edge_ack", 32'(bus.ack), 32'd0);
        check("pop_edge_count", 32'(count), 32'(DEPTH - 1));
        check("pop_edge_head", 32'(bus.o_data), 32'h02);
        tick();
        check("refill_ack", 32'(bus.ack), 32'd1);
        check("refill_count", 32'(count), 32'(DEPTH));
        bus.req = 1'b0;
        wait_ack(1'b0, "refill_ack_fall");
        drain(8'h02, 4);

        // Push and pop on the same edge with two entries queued.
        send_token(8'h20);
        send_token(8'h21);
        check("pp_pre_count", 32'(count), 32'd2);
        bus.data = 8'h22;
        bus.req  = 1'b1;
        repeat (SYNC) tick();
        check("pp_latency_ack", 32'(bus.ack), 32'd0);
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
        check("pp_ack", 32'(bus.ack), 32'd1);
        check("pp_count", 32'(count), 32'd2);
        check("pp_head", 32'(bus.o_data), 32'h21);
        bus.req = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        drain(8'h21, 2);

        // Reset while ACKED with three entries; req stays high across release.
        send_token(8'h30);
        send_token(8'h31);
        bus.data = 8'h32;
        bus.req  = 1'b1;
        wait_ack(1'b1, "mid_ack_rise");
        check("mid_pre_count", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (SYNC) tick();
        check("recap_wait_ack", 32'(bus.ack), 32'd0);
        check("recap_wait_count", 32'(count), 32'd0);
        tick();
        check("recap_ack", 32'(bus.ack), 32'd1);
        check("recap_count", 32'(count), 32'd1);
        check("recap_data", 32'(bus.o_data), 32'h32);
        bus.req = 1'b0;
        wait_ack(1'b0, "recap_ack_fall");
        drain(8'h32, 1);

        // Randomized stream of 0x10..0x19 with random consumer back-pressure.
        begin
            int           sent = 0;
            int           recv = 0;
            int           gap  = 0;
            int           pre_size;
            logic         pre_pop;
            logic         pre_ack;
            logic [N-1:0] pre_data;
            logic [N-1:0] exp;
            q.delete();
            for (int cyc = 0; cyc < 2000 && recv < 10; cyc++) begin
                pre_pop  = bus.o_valid && bus.o_ready;
                pre_ack  = bus.ack;
                pre_data = bus.o_data;
                pre_size = q.size();
                tick();
                if (pre_pop) begin
                    if (q.size() == 0) begin
                        check("rnd_pop_underflow", 32'd1, 32'd0);
                    end else begin
                        exp = q.pop_front();
                        check("rnd_data", 32'(pre_data), 32'(exp));
                    end
                    recv++;
                end
                if (!pre_ack && bus.ack) begin
                    check("rnd_push_space", 32'(pre_size < DEPTH), 32'd1);
                    q.push_back(bus.data);
                end
                check("rnd_count", 32'(count), 32'(q.size()));
                check("rnd_valid", 32'(bus.o_valid), 32'(q.size() != 0));
                if (bus.req && bus.ack) begin
                    bus.req = 1'b0;
                end else if (!bus.req && !bus.ack && sent < 10) begin
                    if (gap == 0) begin
                        bus.data = 8'h10 + N'(sent);
                        bus.req  = 1'b1;
                        sent++;
                        gap = int'($urandom_range(0, 3));
                    end else begin
                        gap--;
                    end
                end
                bus.o_ready = 1'($urandom_range(0, 1));
            end
            bus.o_ready = 1'b0;
            check("rnd_all_received", 32'(recv), 32'd10);
            check("rnd_model_empty", 32'(q.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bd_sync_rx.md
# bd_sync_rx

Receiver stage that sits directly downstream of a bundled-data delay bank. It accepts a 4-phase, return-to-zero bundled-data channel: the request arrives already delayed to match the data path, and the data is held stable until acknowledge. The block synchronises the request into a single clock domain, captures each token into a small FIFO, and presents it on a clocked valid/ready interface. It is the async-to-sync boundary for the delay-matched pipelines.

## Interface

Parameters:
- N, 1: data width of the bundled channel and the output.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC, 2: request synchroniser stages, ≥2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; released synchronously by the environment).
- req  in  1  bundled-data request, asynchronous to clk; arrives after the matched delay.
- data  in  N  bundled data; stable from req rise until ack rise.
- ack  out  1  4-phase acknowledge, registered.
- o_data  out  N  FIFO head entry.
- o_valid  out  1  FIFO not empty.
- o_ready  in  1  consumer accepts o_data when o_valid & o_ready at a rising edge.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation

- Synchroniser: SYNC-flop chain on req; the last stage is req_s. Only req_s is used by the FSM. data is sampled unsynchronised; the bundling constraint guarantees stability.
- FSM states:
  - IDLE: ack=0. Entered from reset. If req_s=1 and count<DEPTH, write data at wr_ptr, set ack<=1, go to ACKED. If req_s=1 and the FIFO is full, stay in IDLE with ack=0 (stall). The channel waits indefinitely.
  - ACKED: ack=1. If req_s=0, set ack<=0 and go to IDLE. Otherwise hold.
- Exactly one write per 4-phase cycle. A second write cannot occur until req has fallen and risen again.
- FIFO:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked explicitly.
  - Pop occurs when o_valid & o_ready. Push and pop may occur on the same edge; count is then unchanged.
  - The full check uses registered count. A same-edge pop does not free space for that edge's push.
  - o_data = mem[rd_ptr]. It is undefined (don't-care) when o_valid=0.
- Overflow and underflow are structurally impossible. A pop with o_valid=0 is ignored.
- Reset (rst=0, any time, including mid-handshake):
  - ack=0, o_valid=0, count=0, pointers=0, sync chain=0, FSM=IDLE.
  - FIFO contents are discarded.
  - A req still high after release is treated as a new token and is captured again.

## Timing

- Reset values: ack=0, o_valid=0, count=0, o_data don't-care.
- Request to capture, from an empty FIFO:
  - req rises before edge E1; req_s=1 after edge E1+SYNC-1.
  - At edge E1+SYNC: write, ack=1, o_valid=1, count=1.
  - Latency is SYNC+1 edges, allowing one extra edge for metastability placement.
- Request release: req falls before edge F1; ack=0 after edge F1+SYNC.
- Full stall: capture occurs on the first edge where req_s=1 and registered count<DEPTH. With a pop at edge P, the write is at edge P+1 at the earliest.
- Throughput: one token per 2·(SYNC+1) cycles plus external req/ack loop delay.
- Output: o_valid and count update on the same edge as push/pop; o_data is valid combinationally from registered state.

## Test plan

- **Reset state:** hold rst=0 with req toggling -> ack=0, o_valid=0, count=0 throughout; after release with req=0, all remain 0.
- **Single token** (N=8, SYNC=2, DEPTH=4): data=0xA5, req rises before edge 1 -> ack=1 and o_valid=1 after edge 3, o_data=0xA5, count=1. Drop req before edge 5 -> ack=0 after edge 7. o_ready=1 pops the token -> o_valid=0.
- **Fill and stall:** o_ready=0, send 4 tokens 0x01..0x04 -> count=4. Fifth req (0x05) -> ack stays 0. Assert o_ready for one edge (pop 0x01) -> ack=1 on the following edge, count returns to 4. Drain order is 0x02,0x03,0x04,0x05.
- **Simultaneous push/pop:** count=2, o_ready=1 on the capture edge -> count stays 2 and order is preserved.
- **Wrap-around:** stream 10 tokens 0x10..0x19 with random o_ready -> the output sequence matches exactly, and pointers wrap twice with no loss or duplication.
- **Mid-handshake reset:** assert rst=0 while in ACKED with count=3 -> ack, o_valid and count are immediately 0. Release with req still high -> token re-captured after SYNC+1 edges, count=1.
